spi_hmc7044_cfg: RTL and testbench

Autonomous power-up SPI write master for the HMC7044 clock generator. After reset it waits a power-up delay, then shifts a fixed internal table of register writes out on a 3-wire write-only SPI bus (SPI mode 0, MSB first, 24-bit frames). It sits beside the clock chip in the board-bring-up logic, has no host interface, and idles with cs high once the table is exhausted.

---
 rtl/spi_hmc7044_cfg.sv | 158 +++++++++++++++
 tb/tb_spi_hmc7044_cfg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_hmc7044_cfg.sv
// rtl/spi_hmc7044_cfg.sv - power-up SPI write master that loads a fixed HMC7044 register table
//
// After reset release the block waits PWR_DLY clk cycles, then sends each table
// entry as one 24-bit SPI mode-0 write frame (MSB first), separated by a cs-high gap.
// Once the table is exhausted it parks with cs high until the next reset.
//
// Ports:
//    clk      system clock
//    rst_n    asynchronous active-low reset
//    spi_clk  SPI serial clock, idles low
//    cs       active-low chip select, idles high
//    spi_mosi serial write data, MSB first
//
// Build option:
//    HMC7044_SOFT_RESET_EN  prepends a soft-reset assert/release pair (reg 0x0000)
//                           to the table, giving 10 frames instead of 8.

module spi_hmc7044_cfg #(
   parameter int HALF_DIV = 5,
   parameter int PWR_DLY  = 1000,
   parameter int GAP      = 10
) (
   input  logic clk,
   input  logic rst_n,
   output logic spi_clk,
   output logic cs,
   output logic spi_mosi
);

`ifdef HMC7044_SOFT_RESET_EN
   localparam int REG_NUM = 10;
`else
   localparam int REG_NUM = 8;
`endif

   typedef enum logic [2:0] {S_WAIT, S_LOAD, S_SHIFT, S_GAP, S_DONE} state_t;

   // Frame = {write bit 0, single-byte 2'b00, addr[12:0], data[7:0]}
   function automatic logic [23:0] frame_word(input logic [3:0] i);
      logic [12:0] a;
      logic [7:0]  d;
      logic [3:0]  k;
`ifdef HMC7044_SOFT_RESET_EN
      if (i == 4'd0) return 24'h000001;
      if (i == 4'd1) return 24'h000000;
      k = i - 4'd2;
`else
      k = i;
`endif
      case (k)
         4'd0:    begin a = 13'h0001; d = 8'h00; end
         4'd1:    begin a = 13'h0002; d = 8'h00; end
         4'd2:    begin a = 13'h0003; d = 8'h2E; end
         4'd3:    begin a = 13'h0004; d = 8'h7F; end
         4'd4:    begin a = 13'h0005; d = 8'h0F; end
         4'd5:    begin a = 13'h0014; d = 8'h18; end
         4'd6:    begin a = 13'h0096; d = 8'h00; end
         4'd7:    begin a = 13'h0001; d = 8'h02; end
         default: begin a = 13'h0000; d = 8'h00; end
      endcase
      return {3'b000, a, d};
   endfunction

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [4:0]  bit_q, bit_d;     // 0..23 data bits, 24 = trailing hold phase
   logic [3:0]  idx_q, idx_d;
   logic [23:0] sh_q, sh_d;       // bits still to send, next one at [23]
   logic        sclk_d, cs_d, mosi_d;

   logic half_end;
   assign half_end = (cnt_q == 32'(HALF_DIV - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_WAIT;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT:  if (cnt_q == 32'(PWR_DLY - 1)) state_d = S_LOAD;
         S_LOAD:  state_d = S_SHIFT;
         S_SHIFT: if (half_end && bit_q == 5'd24) state_d = S_GAP;
         S_GAP:   if (cnt_q == 32'(GAP - 1))
                     state_d = (idx_q == 4'(REG_NUM - 1)) ? S_DONE : S_LOAD;
         default: state_d = S_DONE;
      endcase
   end

   // output / datapath logic: computes the values registered on the next edge
   always_comb begin
      cnt_d  = cnt_q + 32'd1;
      bit_d  = bit_q;
      idx_d  = idx_q;
      sh_d   = sh_q;
      sclk_d = spi_clk;
      cs_d   = cs;
      mosi_d = spi_mosi;
      case (state_q)
         S_WAIT: if (cnt_q == 32'(PWR_DLY - 1)) cnt_d = '0;
         S_LOAD: begin
            cnt_d  = '0;
            bit_d  = '0;
            sh_d   = {frame_word(idx_q)[22:0], 1'b0};
            mosi_d = frame_word(idx_q)[23];
            cs_d   = 1'b0;
            sclk_d = 1'b0;
         end
         S_SHIFT: if (half_end) begin
            cnt_d = '0;
            if (bit_q == 5'd24) begin
               // hold phase over: release cs with idle outputs
               cs_d   = 1'b1;
               sclk_d = 1'b0;
               mosi_d = 1'b0;
            end else if (!spi_clk) begin
               sclk_d = 1'b1;
            end else begin
               // falling edge is the only point mosi moves; zeros fill in
               // behind the data so mosi is 0 during the hold phase
               sclk_d = 1'b0;
               mosi_d = sh_q[23];
               sh_d   = {sh_q[22:0], 1'b0};
               bit_d  = bit_q + 5'd1;
            end
         end
         S_GAP: if (cnt_q == 32'(GAP - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 4'd1;
         end
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         bit_q    <= '0;
         idx_q    <= '0;
         sh_q     <= '0;
         spi_clk  <= 1'b0;
         cs       <= 1'b1;
         spi_mosi <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         idx_q    <= idx_d;
         sh_q     <= sh_d;
         spi_clk  <= sclk_d;
         cs       <= cs_d;
         spi_mosi <= mosi_d;
      end
   end

endmodule

// File: tb/tb_spi_hmc7044_cfg.sv
// tb/tb_spi_hmc7044_cfg.sv - self-checking bench for spi_hmc7044_cfg

module tb_spi_hmc7044_cfg;

   localparam int HD  = 5;
   localparam int PWR = 1000;
   localparam int GP  = 10;
   localparam int FL  = 49 * HD;       // cs-low cycles per frame
   localparam int P   = FL + GP + 1;   // cs-fall to cs-fall period

`ifdef HMC7044_SOFT_RESET_EN
   localparam int N = 10;
   logic [23:0] exp_tab [0:N-1] = '{24'h000001, 24'h000000,
      24'h000100, 24'h000200, 24'h00032E, 24'h00047F,
      24'h00050F, 24'h001418, 24'h009600, 24'h000102};
`else
   localparam int N = 8;
   logic [23:0] exp_tab [0:N-1] = '{24'h000100, 24'h000200, 24'h00032E, 24'h00047F,
      24'h00050F, 24'h001418, 24'h009600, 24'h000102};
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic spi_clk, cs, spi_mosi;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   int          fall_q [$];
   logic [23:0] word_q [$];
   int          rise_q [$];
   int          low_q  [$];
   logic [23:0] word = '0;
   int          nrise = 0;
   int          low_cnt = 0;
   logic        prev_cs = 1'b1;

   spi_hmc7044_cfg #(.HALF_DIV(HD), .PWR_DLY(PWR), .GAP(GP)) dut (
      .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .cs(cs), .spi_mosi(spi_mosi));

   always #10 clk = ~clk;

   // posedges seen since the last reset release
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected outputs after c posedges since release, straight from the frame timeline
   function automatic void model(input int c, output logic ecs, output logic eclk,
                                 output logic emosi, output logic care);
      int t, f, o, b;
      ecs = 1'b1; eclk = 1'b0; emosi = 1'b0; care = 1'b1;
      t = c - (PWR + 1);
      if (t >= 0) begin
         f = t / P;
         o = t % P;
         if (f < N && o < FL) begin
            ecs = 1'b0;
            b = o / (2 * HD);
            if (b < 24) begin
               eclk  = (o % (2 * HD)) >= HD;
               emosi = exp_tab[f][23 - b];
            end else begin
               care = 1'b0;
            end
         end
      end
   endfunction

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (word_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("frames_seen", 32'(word_q.size() >= n), 32'd1);
   endtask

   task automatic clear_q();
      fall_q.delete(); word_q.delete(); rise_q.delete(); low_q.delete();
   endtask

   initial begin
      logic ecs, eclk, emosi, care;
      int nf, k, target;

      fork
         forever begin
            @(negedge clk);
            if (chk_en) begin
               model(cyc, ecs, eclk, emosi, care);
               check($sformatf("outputs@cyc%0d {cs,sclk,mosi}", cyc),
                     {29'd0, cs, spi_clk, care ? spi_mosi : 1'b0},
                     {29'd0, ecs, eclk, care ? emosi : 1'b0});
            end
            if (rst_n) begin
               if (prev_cs === 1'b1 && cs === 1'b0) begin
                  fall_q.push_back(cyc);
                  word = '0; nrise = 0; low_cnt = 0;
               end
               if (cs === 1'b0) low_cnt++;
               if (prev_cs === 1'b0 && cs === 1'b1) begin
                  word_q.push_back(word);
                  rise_q.push_back(nrise);
                  low_q.push_back(low_cnt);
               end
            end
            prev_cs = cs;
         end
         forever begin
            @(posedge spi_clk);
            if (cs === 1'b0) begin
               word = {word[22:0], spi_mosi};
               nrise++;
            end
         end
      join_none

      #12;
      check("reset_cs", {31'd0, cs}, 32'd1);
      check("reset_spi_clk", {31'd0, spi_clk}, 32'd0);
      check("reset_mosi", {31'd0, spi_mosi}, 32'd0);
      chk_en = 1'b1;
      #2 rst_n = 1'b1;

      wait_frames(N, PWR + 1 + N * P + 500);
      check("first_fall_cycle", fall_q[0], 32'd1001);
      check("frame0_cs_low", low_q[0], 32'd245);
      check("frame_period", fall_q[1] - fall_q[0], 32'd256);
      for (int i = 0; i < N; i++) begin
         check($sformatf("frame%0d_word", i), {8'd0, word_q[i]}, {8'd0, exp_tab[i]});
         check($sformatf("frame%0d_rises", i), rise_q[i], 32'd24);
         check($sformatf("frame%0d_cs_low", i), low_q[i], FL);
         if (i > 0) check($sformatf("frame%0d_period", i), fall_q[i] - fall_q[i-1], P);
      end

      nf = fall_q.size();
      repeat (10000) @(negedge clk);
      check("done_no_new_frames", fall_q.size(), nf);
      check("done_cs", {31'd0, cs}, 32'd1);
      check("done_spi_clk", {31'd0, spi_clk}, 32'd0);

      // fresh start, then interrupt frame 3 during bit 10
      @(negedge clk);
      rst_n = 1'b0;
      clear_q();
      repeat (2) @(negedge clk);
      #4 rst_n = 1'b1;
      target = PWR + 1 + 3 * P + 20 * HD + 3;
      k = 0;
      while (cyc < target && k < target + 100) begin
         @(negedge clk);
         k++;
      end
      check("midframe_reached", 32'(cyc), 32'(target));
      check("midframe_cs_low", {31'd0, cs}, 32'd0);
      #3 rst_n = 1'b0;
      #1;
      check("async_cs", {31'd0, cs}, 32'd1);
      check("async_spi_clk", {31'd0, spi_clk}, 32'd0);
      check("async_mosi", {31'd0, spi_mosi}, 32'd0);
      repeat (3) @(negedge clk);
      clear_q();
      #4 rst_n = 1'b1;
      wait_frames(1, PWR + P + 200);
      check("restart_first_fall", fall_q[0], 32'd1001);
      check("restart_frame0_word", {8'd0, word_q[0]}, {8'd0, exp_tab[0]});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
